// File: rtl/wb_port_arbiter_if.sv
// Bundle of the register-file write-port, long-latency result and hazard-check signals.
// The slave modport is the arbiter's view; the master modport is the surrounding core's view.
interface wb_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     pipe_we;
    logic [ADDRESS_WIDTH-1:0] pipe_rd;
    logic [DATA_WIDTH-1:0]    pipe_wd;
    logic                     lu_valid;
    logic [ADDRESS_WIDTH-1:0] lu_rd;
    logic [DATA_WIDTH-1:0]    lu_wd;
    logic                     lu_ready;
    logic                     issue_valid;
    logic [ADDRESS_WIDTH-1:0] issue_rd;
    logic [ADDRESS_WIDTH-1:0] chk_rs1;
    logic [ADDRESS_WIDTH-1:0] chk_rs2;
    logic [ADDRESS_WIDTH-1:0] chk_rd;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic                     rd_busy;
    logic                     pipe_hold;
    logic                     WE3;
    logic [ADDRESS_WIDTH-1:0] AD3;
    logic [DATA_WIDTH-1:0]    WD3;

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd,
        input  lu_valid, lu_rd, lu_wd,
        output lu_ready,
        input  issue_valid, issue_rd,
        input  chk_rs1, chk_rs2, chk_rd,
        output rs1_busy, rs2_busy, rd_busy,
        output pipe_hold,
        output WE3, AD3, WD3
    );

    modport master (
        output pipe_we, pipe_rd, pipe_wd,
        output lu_valid, lu_rd, lu_wd,
        input  lu_ready,
        output issue_valid, issue_rd,
        output chk_rs1, chk_rs2, chk_rd,
        input  rs1_busy, rs2_busy, rd_busy,
        input  pipe_hold,
        input  WE3, AD3, WD3
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback (priority) and a
// queued long-latency result stream, with a busy-register scoreboard and a starvation guard.
module wb_port_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [ADDRESS_WIDTH-1:0] rd_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    wd_mem_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [SW-1:0]            starve_q, starve_d;
    logic                     pipe_hold_q, pipe_hold_d;
    logic [NREG-1:0]          busy_q, busy_d;

    logic                     fifo_empty_s, fifo_full_s;
    logic                     pipe_wr_s, pop_s, push_s;
    logic                     we_s;
    logic [ADDRESS_WIDTH-1:0] ad_s;
    logic [DATA_WIDTH-1:0]    wd_s;
    logic [NREG-1:0]          clr_mask_s, set_mask_s;

    // Write-port mux: pipeline first unless a forced drain is in progress, then FIFO head.
    always_comb begin
        fifo_empty_s = (count_q == CW'(0));
        fifo_full_s  = (count_q == CW'(FIFO_DEPTH));
        pipe_wr_s    = bus.pipe_we && (bus.pipe_rd != '0) && !pipe_hold_q;
        push_s       = bus.lu_valid && !fifo_full_s && (bus.lu_rd != '0);
        we_s         = 1'b0;
        ad_s         = '0;
        wd_s         = '0;
        pop_s        = 1'b0;
        if (pipe_wr_s) begin
            we_s = 1'b1;
            ad_s = bus.pipe_rd;
            wd_s = bus.pipe_wd;
        end else if (!fifo_empty_s) begin
            we_s  = 1'b1;
            ad_s  = rd_mem_q[rd_ptr_q];
            wd_s  = wd_mem_q[rd_ptr_q];
            pop_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Next-state for FIFO bookkeeping, scoreboard and starvation guard.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Clear applied before set so a same-cycle issue to the popped register stays busy.
        clr_mask_s = pop_s ? (NREG'(1) << ad_s) : '0;
        set_mask_s = (bus.issue_valid && (bus.issue_rd != '0)) ? (NREG'(1) << bus.issue_rd) : '0;
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~NREG'(1);

        if (fifo_empty_s || pop_s) begin
            starve_d = SW'(0);
        end else begin
            starve_d = starve_q + SW'(1);
        end
        pipe_hold_d = !fifo_empty_s && !pop_s && (starve_q == SW'(STARVE_LIMIT - 1));
    end

    // State registers; reset discards queued results and clears every busy bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_mem_q[i] <= '0;
                wd_mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            pipe_hold_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            if (push_s) begin
                rd_mem_q[wr_ptr_q] <= bus.lu_rd;
                wd_mem_q[wr_ptr_q] <= bus.lu_wd;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            pipe_hold_q <= pipe_hold_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.lu_ready  = !fifo_full_s;
    assign bus.pipe_hold = pipe_hold_q;
    assign bus.WE3       = we_s;
    assign bus.AD3       = ad_s;
    assign bus.WD3       = wd_s;
    assign bus.rs1_busy  = busy_q[bus.chk_rs1] && (bus.chk_rs1 != '0);
    assign bus.rs2_busy  = busy_q[bus.chk_rs2] && (bus.chk_rs2 != '0);
    assign bus.rd_busy   = busy_q[bus.chk_rd]  && (bus.chk_rd  != '0);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's port and status
// outputs; a negedge monitor pops and compares them.
module tb_wb_port_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
    } res_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic          lu_ready;
        logic          hold;
        logic          b1, b2, b3;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_port_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    res_t lu_q[$];
    bit   busy_m[2**AW];
    int   run_m = 0;
    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total_cnt++;
        if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        else pass_cnt++;
    endtask

    // One core cycle: apply inputs after the edge, predict outputs, advance the model.
    task automatic drive(input bit r, input bit pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pwd,
                         input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] lwd,
                         input bit iv, input logic [AW-1:0] ird,
                         input logic [AW-1:0] c1, input logic [AW-1:0] c2, input logic [AW-1:0] c3);
        exp_t e;
        res_t h;
        bit   hold_m, pw, pop, was_nonempty, accept;
        @(posedge clk);
        #1;
        if (r) begin
            lu_q.delete();
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            run_m = 0;
        end
        hold_m = (run_m == LIMIT);
        if (hold_m || r) pwe = 1'b0;
        if (r || busy_m[ird]) iv = 1'b0;
        if (r) lv = 1'b0;

        rst             = r;
        bus.pipe_we     = pwe;  bus.pipe_rd = prd;  bus.pipe_wd = pwd;
        bus.lu_valid    = lv;   bus.lu_rd   = lrd;  bus.lu_wd   = lwd;
        bus.issue_valid = iv;   bus.issue_rd = ird;
        bus.chk_rs1     = c1;   bus.chk_rs2 = c2;   bus.chk_rd  = c3;

        pw  = pwe && (prd != '0) && !hold_m;
        pop = !pw && (lu_q.size() > 0);
        e.we = 1'b0; e.ad = '0; e.wd = '0;
        if (pw) begin
            e.we = 1'b1; e.ad = prd; e.wd = pwd;
        end else if (pop) begin
            e.we = 1'b1; e.ad = lu_q[0].rd; e.wd = lu_q[0].wd;
        end
        e.lu_ready = (lu_q.size() < DEPTH);
        e.hold     = hold_m;
        e.b1       = (c1 != '0) && busy_m[c1];
        e.b2       = (c2 != '0) && busy_m[c2];
        e.b3       = (c3 != '0) && busy_m[c3];
        exp_q.push_back(e);

        if (!r) begin
            was_nonempty = (lu_q.size() > 0);
            accept       = lv && (lu_q.size() < DEPTH) && (lrd != '0);
            if (pop) begin
                h = lu_q.pop_front();
                busy_m[h.rd] = 1'b0;
            end
            if (iv && ird != '0) busy_m[ird] = 1'b1;
            if (accept) begin
                h.rd = lrd; h.wd = lwd;
                lu_q.push_back(h);
            end
            if (was_nonempty && !pop) run_m++;
            else run_m = 0;
        end
    endtask

    task automatic idle(input int n, input logic [AW-1:0] c);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, c, 0, c);
    endtask

    // Monitor: every cycle the DUT presents port and status outputs, compare with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("WE3",       DW'(bus.WE3),       DW'(e.we));
                check("AD3",       DW'(bus.AD3),       DW'(e.ad));
                check("WD3",       bus.WD3,            e.wd);
                check("lu_ready",  DW'(bus.lu_ready),  DW'(e.lu_ready));
                check("pipe_hold", DW'(bus.pipe_hold), DW'(e.hold));
                check("rs1_busy",  DW'(bus.rs1_busy),  DW'(e.b1));
                check("rs2_busy",  DW'(bus.rs2_busy),  DW'(e.b2));
                check("rd_busy",   DW'(bus.rd_busy),   DW'(e.b3));
            end
        end
    end

    initial begin
        bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_wd = '0;
        bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_wd = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;

        // Reset then idle.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 5'd0);

        // Simultaneous pipeline write and long-latency result.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 0);
        drive(0, 1, 5'd5, 32'hA5, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0, 5'd7);
        idle(3, 5'd7);

        // Busy on x9 until its result pops; x0 never busy.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0, 5'd9);
        drive(0, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 5'd9, 5'd0, 5'd9);
        idle(2, 5'd9);

        // Fill the FIFO under a busy pipeline and let the starvation guard force drains.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 5'd10, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 5'd11, 0, 0);
        drive(0, 1, 5'd4, 32'h40, 1, 5'd10, 32'h1010, 0, 0, 5'd10, 5'd11, 0);
        drive(0, 1, 5'd4, 32'h41, 1, 5'd11, 32'h1111, 0, 0, 5'd10, 5'd11, 0);
        drive(0, 1, 5'd4, 32'h42, 1, 5'd12, 32'h1212, 0, 0, 5'd10, 5'd11, 5'd12);
        for (int i = 0; i < 20; i++) drive(0, 1, 5'd4, 32'h100 + i, 0, 0, 0, 0, 0, 5'd10, 5'd11, 0);
        idle(2, 5'd11);

        // x0 destinations are discarded on both sources.
        drive(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 0, 0, 0, 0, 0);
        idle(2, 5'd0);

        // Reset with two queued entries and busy[3].
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 0, 5'd3);
        drive(0, 1, 5'd6, 32'h60, 1, 5'd3, 32'h33, 0, 0, 5'd3, 0, 5'd3);
        drive(0, 1, 5'd6, 32'h61, 1, 5'd8, 32'h88, 0, 0, 5'd3, 0, 5'd3);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3, 5'd3);
        idle(4, 5'd3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(0,
                  ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), DW'($urandom),
                  ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), DW'($urandom),
                  ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(12, 5'd0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
